// File: rtl/ibex_pkg.sv
// PMP CSR file types and CSR address map.
package ibex_pkg;

   typedef enum logic [1:0] {
      PMP_MODE_OFF   = 2'b00,
      PMP_MODE_TOR   = 2'b01,
      PMP_MODE_NA4   = 2'b10,
      PMP_MODE_NAPOT = 2'b11
   } pmp_cfg_mode_e;

   typedef struct packed {
      logic          lock;
      pmp_cfg_mode_e mode;
      logic          exec;
      logic          write;
      logic          read;
   } pmp_cfg_t;

   // Field order matches the mseccfg bit layout {rlb, mmwp, mml}.
   typedef struct packed {
      logic rlb;
      logic mmwp;
      logic mml;
   } pmp_mseccfg_t;

   localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
   localparam logic [11:0] CSR_PMPCFG1   = 12'h3A1;
   localparam logic [11:0] CSR_PMPCFG2   = 12'h3A2;
   localparam logic [11:0] CSR_PMPCFG3   = 12'h3A3;
   localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
   localparam logic [11:0] CSR_PMPADDR1  = 12'h3B1;
   localparam logic [11:0] CSR_PMPADDR2  = 12'h3B2;
   localparam logic [11:0] CSR_PMPADDR3  = 12'h3B3;
   localparam logic [11:0] CSR_PMPADDR4  = 12'h3B4;
   localparam logic [11:0] CSR_PMPADDR5  = 12'h3B5;
   localparam logic [11:0] CSR_PMPADDR6  = 12'h3B6;
   localparam logic [11:0] CSR_PMPADDR7  = 12'h3B7;
   localparam logic [11:0] CSR_PMPADDR8  = 12'h3B8;
   localparam logic [11:0] CSR_PMPADDR9  = 12'h3B9;
   localparam logic [11:0] CSR_PMPADDR10 = 12'h3BA;
   localparam logic [11:0] CSR_PMPADDR11 = 12'h3BB;
   localparam logic [11:0] CSR_PMPADDR12 = 12'h3BC;
   localparam logic [11:0] CSR_PMPADDR13 = 12'h3BD;
   localparam logic [11:0] CSR_PMPADDR14 = 12'h3BE;
   localparam logic [11:0] CSR_PMPADDR15 = 12'h3BF;
   localparam logic [11:0] CSR_MSECCFG   = 12'h747;
   localparam logic [11:0] CSR_MSECCFGH  = 12'h757;

endpackage

// File: rtl/ibex_pmp_cfg_legalise.sv
// Per-entry write legalisation: decides whether a cfg byte / pmpaddr write
// may land, and produces the WARL-legal cfg value.
module ibex_pmp_cfg_legalise
   import ibex_pkg::*;
#(
   parameter int PMPGranularity = 0
) (
   input  pmp_cfg_t      cfg_i,
   input  logic [7:0]    wdata_i,
   input  logic          mml_i,
   input  logic          rlb_i,
   input  logic          next_lock_i,
   input  pmp_cfg_mode_e next_mode_i,
   output logic          cfg_we_o,
   output pmp_cfg_t      cfg_o,
   output logic          addr_we_o
);

   logic          locked;
   logic          reserved_rw;
   logic          mml_deny;
   pmp_cfg_mode_e new_mode;

   // Only the lock bit of the current entry matters; [6:5] of the byte are WARL zero.
   logic unused_inputs;
   assign unused_inputs = ^{cfg_i.mode, cfg_i.exec, cfg_i.write, cfg_i.read, wdata_i[6:5]};

   // Legal value, then the three reasons a byte is dropped and the addr lock check.
   always_comb begin
      new_mode = pmp_cfg_mode_e'(wdata_i[4:3]);
      // NA4 cannot describe a region when the granule exceeds 4 bytes.
      if (PMPGranularity >= 1 && new_mode == PMP_MODE_NA4) new_mode = PMP_MODE_OFF;
      cfg_o = '{lock: wdata_i[7], mode: new_mode, exec: wdata_i[2],
                write: wdata_i[1], read: wdata_i[0]};

      locked      = cfg_i.lock & ~rlb_i;
      reserved_rw = ~wdata_i[0] & wdata_i[1] & ~mml_i;
      // Under MML, new locked rules may not be M-mode executable or shared.
      mml_deny    = mml_i & ~rlb_i & wdata_i[7] &
                    ((wdata_i[2] & ~(wdata_i[0] & wdata_i[1])) | (~wdata_i[0] & wdata_i[1]));
      cfg_we_o    = ~(locked | reserved_rw | mml_deny);

      // A locked TOR entry above also freezes this entry's address (its base).
      addr_we_o   = ~locked & ~(next_lock_i & ~rlb_i & (next_mode_i == PMP_MODE_TOR));
   end

endmodule

// File: rtl/ibex_pmp_csr_file.sv
// PMP configuration CSR file: pmpcfg0-3, pmpaddr0-15, mseccfg/mseccfgh.
// Holds legalised state, feeds the PMP checker and returns CSR read data.
module ibex_pmp_csr_file
   import ibex_pkg::*;
#(
   parameter int PMPGranularity = 0,
   parameter int PMPNumRegions  = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         csr_access_i,
   input  logic         csr_we_i,
   input  logic [11:0]  csr_addr_i,
   input  logic [31:0]  csr_wdata_i,
   output logic [31:0]  csr_rdata_o,
   output logic         csr_hit_o,
   output pmp_cfg_t     csr_pmp_cfg_o     [PMPNumRegions],
   output logic [33:0]  csr_pmp_addr_o    [PMPNumRegions],
   output pmp_mseccfg_t csr_pmp_mseccfg_o
);

   // Read-side address masks: OFF/TOR clear [G-1:0], NAPOT sets [G-2:0].
   localparam int          NapotShift = (PMPGranularity >= 1) ? PMPGranularity - 1 : 0;
   localparam logic [31:0] OffTorMask = (32'd1 << PMPGranularity) - 32'd1;
   localparam logic [31:0] NapotMask  = (PMPGranularity >= 1) ?
                                        ((32'd1 << NapotShift) - 32'd1) : 32'd0;

   pmp_cfg_t     cfg_q   [PMPNumRegions];
   pmp_cfg_t     cfg_d   [PMPNumRegions];
   logic [31:0]  addr_q  [PMPNumRegions];
   logic [31:0]  addr_d  [PMPNumRegions];
   pmp_mseccfg_t mseccfg_q, mseccfg_d;

   pmp_cfg_t                 cfg_leg [PMPNumRegions];
   logic [PMPNumRegions-1:0] cfg_we;
   logic [PMPNumRegions-1:0] addr_we;

   logic cfg_sel, addr_sel, msec_sel, msech_sel, csr_wr, any_lock;

   assign cfg_sel   = csr_addr_i[11:2] == CSR_PMPCFG0[11:2];
   assign addr_sel  = csr_addr_i[11:4] == CSR_PMPADDR0[11:4];
   assign msec_sel  = csr_addr_i == CSR_MSECCFG;
   assign msech_sel = csr_addr_i == CSR_MSECCFGH;
   assign csr_hit_o = cfg_sel | addr_sel | msec_sel | msech_sel;
   assign csr_wr    = csr_access_i & csr_we_i & csr_hit_o;

   for (genvar i = 0; i < PMPNumRegions; i++) begin : g_entry
      localparam bit HasNext = (i + 1) < PMPNumRegions;
      localparam int Nxt     = HasNext ? i + 1 : i;

      ibex_pmp_cfg_legalise #(
         .PMPGranularity(PMPGranularity)
      ) u_legalise (
         .cfg_i      (cfg_q[i]),
         .wdata_i    (csr_wdata_i[8*(i%4) +: 8]),
         .mml_i      (mseccfg_q.mml),
         .rlb_i      (mseccfg_q.rlb),
         .next_lock_i(HasNext & cfg_q[Nxt].lock),
         .next_mode_i(HasNext ? cfg_q[Nxt].mode : PMP_MODE_OFF),
         .cfg_we_o   (cfg_we[i]),
         .cfg_o      (cfg_leg[i]),
         .addr_we_o  (addr_we[i])
      );

      assign csr_pmp_cfg_o[i]  = cfg_q[i];
      assign csr_pmp_addr_o[i] = {addr_q[i], 2'b00};
   end

   assign csr_pmp_mseccfg_o = mseccfg_q;

   // Any lock (pre-write) blocks setting RLB.
   always_comb begin
      any_lock = 1'b0;
      for (int i = 0; i < PMPNumRegions; i++) any_lock = any_lock | cfg_q[i].lock;
   end

   // Next state: all lock decisions use pre-write state.
   always_comb begin
      cfg_d     = cfg_q;
      addr_d    = addr_q;
      mseccfg_d = mseccfg_q;
      if (csr_wr) begin
         for (int i = 0; i < PMPNumRegions; i++) begin
            if (cfg_sel && csr_addr_i[1:0] == 2'(i / 4) && cfg_we[i]) cfg_d[i] = cfg_leg[i];
            if (addr_sel && csr_addr_i[3:0] == 4'(i) && addr_we[i]) addr_d[i] = csr_wdata_i;
         end
         if (msec_sel) begin
            mseccfg_d.mml  = mseccfg_q.mml  | csr_wdata_i[0];
            mseccfg_d.mmwp = mseccfg_q.mmwp | csr_wdata_i[1];
            if (!(csr_wdata_i[2] && !mseccfg_q.rlb && any_lock)) mseccfg_d.rlb = csr_wdata_i[2];
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < PMPNumRegions; i++) begin
            cfg_q[i]  <= '0;
            addr_q[i] <= '0;
         end
         mseccfg_q <= '0;
      end else begin
         cfg_q     <= cfg_d;
         addr_q    <= addr_d;
         mseccfg_q <= mseccfg_d;
      end
   end

   // Combinational read mux; unimplemented entries and misses read 0.
   always_comb begin
      csr_rdata_o = '0;
      for (int i = 0; i < PMPNumRegions; i++) begin
         if (cfg_sel && csr_addr_i[1:0] == 2'(i / 4)) begin
            csr_rdata_o[8*(i%4) +: 8] = {cfg_q[i].lock, 2'b00, cfg_q[i].mode,
                                         cfg_q[i].exec, cfg_q[i].write, cfg_q[i].read};
         end
         if (addr_sel && csr_addr_i[3:0] == 4'(i)) begin
            if (cfg_q[i].mode == PMP_MODE_NAPOT)    csr_rdata_o = addr_q[i] | NapotMask;
            else if (cfg_q[i].mode == PMP_MODE_NA4) csr_rdata_o = addr_q[i];
            else                                    csr_rdata_o = addr_q[i] & ~OffTorMask;
         end
      end
      if (msec_sel) csr_rdata_o = {29'd0, mseccfg_q.rlb, mseccfg_q.mmwp, mseccfg_q.mml};
   end

endmodule

// File: tb/tb_ibex_pmp_csr_file.sv
// Directed bench: dut1 is G=0/4 regions, dut2 is G=2/16 regions, shared CSR bus.
module tb_ibex_pmp_csr_file;
   import ibex_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         csr_access = 1'b0;
   logic         csr_we = 1'b0;
   logic [11:0]  csr_addr = '0;
   logic [31:0]  csr_wdata = '0;

   logic [31:0]  rdata1, rdata2;
   logic         hit1, hit2;
   pmp_cfg_t     cfg1 [4];
   logic [33:0]  addr1 [4];
   pmp_mseccfg_t ms1;
   pmp_cfg_t     cfg2 [16];
   logic [33:0]  addr2 [16];
   pmp_mseccfg_t ms2;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ibex_pmp_csr_file #(.PMPGranularity(0), .PMPNumRegions(4)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .csr_access_i(csr_access), .csr_we_i(csr_we),
      .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .csr_rdata_o(rdata1),
      .csr_hit_o(hit1), .csr_pmp_cfg_o(cfg1), .csr_pmp_addr_o(addr1),
      .csr_pmp_mseccfg_o(ms1)
   );

   ibex_pmp_csr_file #(.PMPGranularity(2), .PMPNumRegions(16)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .csr_access_i(csr_access), .csr_we_i(csr_we),
      .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .csr_rdata_o(rdata2),
      .csr_hit_o(hit2), .csr_pmp_cfg_o(cfg2), .csr_pmp_addr_o(addr2),
      .csr_pmp_mseccfg_o(ms2)
   );

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      csr_access = 1'b0;
      csr_we     = 1'b0;
      rst_n      = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Write one CSR; old1 is dut1 read data in the write cycle (pre-commit).
   task automatic wr(input logic [11:0] a, input logic [31:0] d, output logic [31:0] old1);
      @(negedge clk);
      csr_access = 1'b1;
      csr_we     = 1'b1;
      csr_addr   = a;
      csr_wdata  = d;
      #1 old1 = rdata1;
      @(posedge clk);
      #1;
      csr_access = 1'b0;
      csr_we     = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] r1, output logic [31:0] r2);
      @(negedge clk);
      csr_access = 1'b1;
      csr_we     = 1'b0;
      csr_addr   = a;
      #1;
      r1 = rdata1;
      r2 = rdata2;
      csr_access = 1'b0;
   endtask

   initial begin
      logic [31:0] r1, r2, old;
      logic [11:0] a;

      // 1: reset state
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a = CSR_PMPCFG0 + 12'(i);
         rd(a, r1, r2);
         chk("rst_pmpcfg_d1", {2'b0, r1}, 34'd0);
         chk("rst_pmpcfg_d2", {2'b0, r2}, 34'd0);
      end
      for (int i = 0; i < 16; i++) begin
         a = CSR_PMPADDR0 + 12'(i);
         rd(a, r1, r2);
         chk("rst_pmpaddr_d1", {2'b0, r1}, 34'd0);
         chk("rst_pmpaddr_d2", {2'b0, r2}, 34'd0);
      end
      rd(CSR_MSECCFG, r1, r2);
      chk("rst_mseccfg", {2'b0, r1}, 34'd0);
      chk("rst_hit_mseccfg", 34'(hit1), 34'd1);
      rd(12'h3C0, r1, r2);
      chk("miss_hit", 34'(hit1), 34'd0);
      chk("miss_rdata", {2'b0, r1}, 34'd0);
      chk("rst_cfg_o", 34'(cfg1[0]), 34'd0);
      chk("rst_cfg_mode", 34'(cfg2[15].mode), 34'(PMP_MODE_OFF));
      chk("rst_addr_o", addr1[3], 34'd0);
      chk("rst_msec_o", 34'(ms2), 34'd0);

      // 2: TOR lock above entry0 freezes addr0; locked entry1 freezes addr1
      wr(CSR_PMPADDR0, 32'h0000_AAAA, old);
      chk("same_cycle_old", {2'b0, old}, 34'd0);
      rd(CSR_PMPADDR0, r1, r2);
      chk("addr0_write", {2'b0, r1}, 34'h0_0000_AAAA);
      chk("addr0_out", addr1[0], 34'h0_0002_AAA8);
      wr(CSR_PMPCFG0, 32'h0000_8F1B, old);
      rd(CSR_PMPCFG0, r1, r2);
      chk("cfg0_d1", {2'b0, r1}, 34'h0_0000_8F1B);
      chk("cfg0_d2", {2'b0, r2}, 34'h0_0000_8F1B);
      chk("cfg1_lock", 34'(cfg1[1].lock), 34'd1);
      chk("cfg1_mode", 34'(cfg1[1].mode), 34'(PMP_MODE_TOR));
      wr(CSR_PMPADDR1, 32'h0000_1234, old);
      rd(CSR_PMPADDR1, r1, r2);
      chk("addr1_locked", {2'b0, r1}, 34'd0);
      wr(CSR_PMPADDR0, 32'h0000_5555, old);
      rd(CSR_PMPADDR0, r1, r2);
      chk("addr0_tor_locked", {2'b0, r1}, 34'h0_0000_AAAA);
      chk("addr0_napot_g2", {2'b0, r2}, 34'h0_0000_AAAB);

      // 3: reserved R=0/W=1, independent bytes, unimplemented entries
      wr(CSR_PMPCFG0, 32'h0000_8F02, old);
      rd(CSR_PMPCFG0, r1, r2);
      chk("cfg_reserved_rw", {2'b0, r1}, 34'h0_0000_8F1B);
      wr(CSR_PMPCFG0, 32'h0D00_8F03, old);
      rd(CSR_PMPCFG0, r1, r2);
      chk("cfg_bytes_indep", {2'b0, r1}, 34'h0_0D00_8F03);
      wr(CSR_PMPCFG3, 32'h0101_0101, old);
      rd(CSR_PMPCFG3, r1, r2);
      chk("cfg3_unimpl_d1", {2'b0, r1}, 34'd0);
      chk("cfg3_impl_d2", {2'b0, r2}, 34'h0_0101_0101);

      // 4: MML sticky, MML denial, mseccfgh
      do_reset();
      wr(CSR_MSECCFG, 32'h1, old);
      wr(CSR_MSECCFG, 32'h0, old);
      rd(CSR_MSECCFG, r1, r2);
      chk("mml_sticky", {2'b0, r1}, 34'd1);
      chk("mml_out", 34'(ms1.mml), 34'd1);
      wr(CSR_PMPCFG0, 32'h0000_008C, old);
      rd(CSR_PMPCFG0, r1, r2);
      chk("mml_deny_lx", {2'b0, r1}, 34'd0);
      wr(CSR_PMPCFG0, 32'h0000_0002, old);
      rd(CSR_PMPCFG0, r1, r2);
      chk("mml_allows_w_only", {2'b0, r1}, 34'h0_0000_0002);
      wr(CSR_MSECCFGH, 32'h0000_0007, old);
      rd(CSR_MSECCFGH, r1, r2);
      chk("mseccfgh_zero", {2'b0, r1}, 34'd0);
      rd(CSR_MSECCFG, r1, r2);
      chk("mseccfg_after_h", {2'b0, r1}, 34'd1);

      // 5: RLB bypass and RLB set blocked by existing locks
      do_reset();
      wr(CSR_MSECCFG, 32'h4, old);
      rd(CSR_MSECCFG, r1, r2);
      chk("rlb_set", {2'b0, r1}, 34'h4);
      wr(CSR_PMPCFG0, 32'h0000_0089, old);
      rd(CSR_PMPCFG0, r1, r2);
      chk("lock_entry0", {2'b0, r1}, 34'h0_0000_0089);
      wr(CSR_PMPCFG0, 32'h0000_0000, old);
      rd(CSR_PMPCFG0, r1, r2);
      chk("rlb_bypass_cfg", {2'b0, r1}, 34'd0);
      wr(CSR_PMPCFG0, 32'h0000_0089, old);
      wr(CSR_PMPADDR0, 32'h0000_0077, old);
      rd(CSR_PMPADDR0, r1, r2);
      chk("rlb_bypass_addr", {2'b0, r1}, 34'h0_0000_0077);
      wr(CSR_MSECCFG, 32'h0, old);
      rd(CSR_MSECCFG, r1, r2);
      chk("rlb_clear", {2'b0, r1}, 34'd0);
      wr(CSR_PMPADDR0, 32'h0000_0088, old);
      rd(CSR_PMPADDR0, r1, r2);
      chk("addr0_locked", {2'b0, r1}, 34'h0_0000_0077);
      wr(CSR_MSECCFG, 32'h4, old);
      rd(CSR_MSECCFG, r1, r2);
      chk("rlb_set_blocked", {2'b0, r1}, 34'd0);

      // Reset asserted during a write cycle: nothing lands
      @(negedge clk);
      csr_access = 1'b1;
      csr_we     = 1'b1;
      csr_addr   = CSR_PMPADDR1;
      csr_wdata  = 32'h0000_0099;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      csr_access = 1'b0;
      csr_we     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd(CSR_PMPADDR1, r1, r2);
      chk("rst_mid_write_addr", {2'b0, r1}, 34'd0);
      rd(CSR_PMPCFG0, r1, r2);
      chk("rst_mid_write_cfg", {2'b0, r1}, 34'd0);

      // 6: granularity read masking (dut2, G=2) and NA4 -> OFF
      do_reset();
      wr(CSR_PMPCFG0, 32'h0000_0018, old);
      wr(CSR_PMPADDR0, 32'h0000_0000, old);
      rd(CSR_PMPADDR0, r1, r2);
      chk("napot_g2_read", {2'b0, r2}, 34'h1);
      chk("napot_g0_read", {2'b0, r1}, 34'h0);
      wr(CSR_PMPCFG0, 32'h0000_0008, old);
      rd(CSR_PMPADDR0, r1, r2);
      chk("tor_g2_read0", {2'b0, r2}, 34'h0);
      wr(CSR_PMPADDR0, 32'h0000_00F7, old);
      rd(CSR_PMPADDR0, r1, r2);
      chk("tor_g2_mask", {2'b0, r2}, 34'h0_0000_00F4);
      chk("tor_g0_nomask", {2'b0, r1}, 34'h0_0000_00F7);
      chk("tor_g2_stored", addr2[0], 34'h0_0000_03DC);
      wr(CSR_PMPCFG0, 32'h0000_0010, old);
      rd(CSR_PMPCFG0, r1, r2);
      chk("na4_g2_off", {2'b0, r2}, 34'h0);
      chk("na4_g0_kept", {2'b0, r1}, 34'h0_0000_0010);
      wr(CSR_PMPADDR15, 32'h0000_0ABC, old);
      rd(CSR_PMPADDR15, r1, r2);
      chk("addr15_d2", {2'b0, r2}, 34'h0_0000_0ABC);
      chk("addr15_unimpl_d1", {2'b0, r1}, 34'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
